blink_rate_sel: RTL and testbench

Upstream control stage for the LED blinker: turns two raw push-buttons into the 32-bit `rate_ms` blink period the blinker consumes. Each button input is synchronised and debounced. A press steps the rate up or down by a fixed amount, and holding a button auto-repeats the step. The result saturates at programmable limits. Pressing both buttons together restores the initial rate.

---
 rtl/blink_rate_sel.sv | 132 +++++++++++++
 tb/tb_blink_rate_sel.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_sel.sv
// Two-button rate selector: synchronises and debounces btn_up/btn_dn, steps a
// saturating rate_ms on press and auto-repeat, and reloads INIT_MS on a both-press.
module blink_rate_sel #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned REPEAT_MS   = 250,
  parameter int unsigned STEP_MS     = 50,
  parameter int unsigned MIN_MS      = 50,
  parameter int unsigned MAX_MS      = 2000,
  parameter int unsigned INIT_MS     = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_up,
  input  logic        btn_dn,
  output logic [31:0] rate_ms,
  output logic        rate_changed,
  output logic        at_min,
  output logic        at_max
);

  // state  | meaning
  // S_IDLE | no stable button high
  // S_UP   | btn_up held alone, repeat timer running
  // S_DN   | btn_dn held alone, repeat timer running
  // S_LOCK | both were seen high; no steps until both released

  localparam logic [31:0] DB_CYC  = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam logic [31:0] RP_CYC  = (CLK_FREQ / 1000) * REPEAT_MS;
  localparam logic [31:0] RP_LAST = RP_CYC - 32'd1;
  localparam logic [31:0] STEP_V  = STEP_MS;
  localparam logic [31:0] MIN_V   = MIN_MS;
  localparam logic [31:0] MAX_V   = MAX_MS;
  localparam logic [31:0] INIT_V  = INIT_MS;

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_LOCK} state_t;

  logic [1:0]       btn_raw;
  logic [1:0]       sync1, sync2, stable;
  logic [1:0][31:0] db_cnt;
  logic             up_s, dn_s;

  state_t      state, state_nxt;
  logic [31:0] rpt_cnt, rpt_cnt_nxt;
  logic        step_up, step_dn, load_init;
  logic [31:0] up_val, dn_val, rate_nxt;

  assign btn_raw = {btn_dn, btn_up};
  assign up_s    = stable[0];
  assign dn_s    = stable[1];

  // Level is accepted only after DB_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] + 32'd1 >= DB_CYC) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = '0;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    load_init   = 1'b0;
    if (up_s && dn_s) begin
      load_init = (state != S_LOCK);
      state_nxt = S_LOCK;
    end else if (state == S_LOCK) begin
      if (!up_s && !dn_s) state_nxt = S_IDLE;
    end else if (up_s) begin
      state_nxt = S_UP;
      if (state != S_UP || rpt_cnt == RP_LAST) step_up = 1'b1;
      else rpt_cnt_nxt = rpt_cnt + 32'd1;
    end else if (dn_s) begin
      state_nxt = S_DN;
      if (state != S_DN || rpt_cnt == RP_LAST) step_dn = 1'b1;
      else rpt_cnt_nxt = rpt_cnt + 32'd1;
    end else begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    up_val   = (rate_ms + STEP_V >= MAX_V) ? MAX_V : rate_ms + STEP_V;
    dn_val   = (rate_ms <= MIN_V + STEP_V) ? MIN_V : rate_ms - STEP_V;
    rate_nxt = rate_ms;
    if (load_init)    rate_nxt = INIT_V;
    else if (step_up) rate_nxt = up_val;
    else if (step_dn) rate_nxt = dn_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_ms      <= INIT_V;
      rate_changed <= 1'b0;
      at_min       <= (INIT_V == MIN_V);
      at_max       <= (INIT_V == MAX_V);
    end else begin
      rate_ms      <= rate_nxt;
      rate_changed <= (rate_nxt != rate_ms);
      at_min       <= (rate_nxt == MIN_V);
      at_max       <= (rate_nxt == MAX_V);
    end
  end

endmodule

// File: tb/tb_blink_rate_sel.sv
// Directed bench for blink_rate_sel at 1 cycle/ms: debounce latency, bounce
// rejection, saturation, auto-repeat spacing, both-button reload and reset.
module tb_blink_rate_sel;

  logic        clk;
  logic        reset_n;
  logic        btn_up;
  logic        btn_dn;
  logic [31:0] rate_ms;
  logic        rate_changed;
  logic        at_min;
  logic        at_max;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  blink_rate_sel #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_MS(10), .STEP_MS(50),
    .MIN_MS(50), .MAX_MS(300), .INIT_MS(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_dn(btn_dn),
    .rate_ms(rate_ms), .rate_changed(rate_changed), .at_min(at_min), .at_max(at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rate_changed) pulses++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pulses  = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rate_ms !== 32'd100) begin
      errors++;
      $display("FAIL reset_rate got %0d expected 100", rate_ms);
    end
    checks++;
    if (rate_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse got %b expected 0", rate_changed);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({at_min, at_max} !== 2'b00) begin
      errors++;
      $display("FAIL reset_limits got %b expected 00", {at_min, at_max});
    end
    checks++;
    if (rate_ms !== 32'd100) begin
      errors++;
      $display("FAIL reset_release_rate got %0d expected 100", rate_ms);
    end
  endtask

  task automatic test_clean_press();
    logic [31:0] r6, r7;
    logic        c7;
    do_reset();
    btn_up = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) r6 = rate_ms;
      if (i == 7) begin r7 = rate_ms; c7 = rate_changed; end
    end
    btn_up = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (r6 !== 32'd100) begin
      errors++;
      $display("FAIL press_edge6 got %0d expected 100", r6);
    end
    checks++;
    if (r7 !== 32'd150 || c7 !== 1'b1) begin
      errors++;
      $display("FAIL press_edge7 got %0d/%b expected 150/1", r7, c7);
    end
    checks++;
    if (pulses != 1 || rate_ms !== 32'd150) begin
      errors++;
      $display("FAIL press_final got %0d pulses rate %0d expected 1 pulse rate 150", pulses, rate_ms);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      btn_up = 1'b1;
      repeat (3) tick();
      btn_up = 1'b0;
      tick();
    end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (rate_ms !== 32'd100 || pulses != 0) begin
      errors++;
      $display("FAIL bounce got rate %0d pulses %0d expected 100 and 0", rate_ms, pulses);
    end
  endtask

  task automatic test_down_sat();
    logic [31:0] r6, r7;
    do_reset();
    btn_dn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 6) r6 = rate_ms;
      if (i == 7) r7 = rate_ms;
    end
    checks++;
    if (r6 !== 32'd100 || r7 !== 32'd50) begin
      errors++;
      $display("FAIL down_step got %0d,%0d expected 100,50", r6, r7);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL down_pulses got %0d expected 1", pulses);
    end
    checks++;
    if (at_min !== 1'b1 || at_max !== 1'b0 || rate_ms !== 32'd50) begin
      errors++;
      $display("FAIL down_limits got min %b max %b rate %0d expected 1 0 50", at_min, at_max, rate_ms);
    end
    btn_dn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_up_repeat();
    logic [31:0] r16, r17, r27, r37;
    do_reset();
    btn_up = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 16) r16 = rate_ms;
      if (i == 17) r17 = rate_ms;
      if (i == 27) r27 = rate_ms;
      if (i == 37) r37 = rate_ms;
    end
    checks++;
    if (r16 !== 32'd150 || r17 !== 32'd200) begin
      errors++;
      $display("FAIL repeat_first got %0d,%0d expected 150,200", r16, r17);
    end
    checks++;
    if (r27 !== 32'd250 || r37 !== 32'd300) begin
      errors++;
      $display("FAIL repeat_later got %0d,%0d expected 250,300", r27, r37);
    end
    checks++;
    if (at_max !== 1'b1 || at_min !== 1'b0) begin
      errors++;
      $display("FAIL repeat_at_max got max %b min %b expected 1 0", at_max, at_min);
    end
    btn_up = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (pulses != 4 || rate_ms !== 32'd300) begin
      errors++;
      $display("FAIL repeat_pulses got %0d rate %0d expected 4 rate 300", pulses, rate_ms);
    end
  endtask

  task automatic test_both_and_reset();
    logic [31:0] r6, r7, q6, q7, q17;
    logic        c7;
    do_reset();
    btn_up = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if (rate_ms !== 32'd200) begin
      errors++;
      $display("FAIL both_setup got %0d expected 200", rate_ms);
    end
    btn_dn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) r6 = rate_ms;
      if (i == 7) begin r7 = rate_ms; c7 = rate_changed; end
    end
    checks++;
    if (r6 !== 32'd200 || r7 !== 32'd100 || c7 !== 1'b1) begin
      errors++;
      $display("FAIL both_load got %0d,%0d pulse %b expected 200,100 pulse 1", r6, r7, c7);
    end
    repeat (3) tick();
    btn_dn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (pulses != 0 || rate_ms !== 32'd100) begin
      errors++;
      $display("FAIL lockout got %0d pulses rate %0d expected 0 pulses rate 100", pulses, rate_ms);
    end
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 6) q6 = rate_ms;
      if (i == 7) q7 = rate_ms;
      if (i == 17) q17 = rate_ms;
    end
    checks++;
    if (q6 !== 32'd100 || q7 !== 32'd150 || q17 !== 32'd200) begin
      errors++;
      $display("FAIL reset_restart got %0d,%0d,%0d expected 100,150,200", q6, q7, q17);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if (rate_ms !== 32'd100 || rate_changed !== 1'b0 || at_max !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold got %0d pulse %b max %b expected 100 0 0", rate_ms, rate_changed, at_max);
    end
    tick();
    btn_up  = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_down_sat();
    test_up_repeat();
    test_both_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
